// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM state and operation
// encodings, counter sizing and the request address legality helper.
package dmem_responder_pkg;

  // Responder FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Captured operation kind.
  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // Wait-state counter width and the largest wait count it can hold.
  localparam int unsigned CNT_WIDTH = 4;
  localparam int unsigned WAIT_MAX  = (1 << CNT_WIDTH) - 1;

  // A byte address is unusable when it is not word aligned or when any bit
  // above the word-address field is set (beyond the end of the array).
  function automatic logic addr_illegal(input logic [31:0] addr,
                                        input int unsigned aw);
    logic [31:0] hi_bits;
    hi_bits = addr >> (aw + 2);
    return (addr[1:0] != 2'b00) || (hi_bits != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word-addressed SRAM: synchronous write, registered read.
// Storage is never reset; only the read-data register clears on reset so the
// responder's read-data output starts at zero.
module dmem_array #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  re_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write port: storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Registered read: the output only changes when a read is committed, so
  // the last read value is held between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the datapath's data port. Accepts one read or
// write at a time, stalls the pipeline for WAIT_CYCLES extra cycles, commits
// the access on the edge that enters DONE and flags illegal requests with a
// one-cycle error pulse.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_en,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_err
);

  // Parameter sanity checks at elaboration time.
  generate
    if (WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
      $error("dmem_responder: WAIT_CYCLES must be in 0..15");
    end
    if ((ADDR_WIDTH < 1) || (ADDR_WIDTH > 30)) begin : g_bad_aw
      $error("dmem_responder: ADDR_WIDTH must be in 1..30");
    end
  endgenerate

  localparam logic [CNT_WIDTH-1:0] WAIT_LOAD = CNT_WIDTH'(WAIT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam bit                   NO_WAIT   = (WAIT_CYCLES == 0);

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  op_e                     op_q, op_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             data_q, data_d;
  logic                    err_q, err_d;

  logic                    in_idle;
  logic                    req_valid;
  logic                    req_illegal;
  logic                    req_accept;
  op_e                     req_op;
  logic [ADDR_WIDTH-1:0]   req_waddr;

  logic                    commit;
  op_e                     acc_op;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [31:0]             acc_data;
  logic                    arr_re;
  logic                    arr_we;

  assign in_idle     = (state_q == ST_IDLE);
  assign req_valid   = in_idle && cpu_en && (mem_ren || mem_wen);
  assign req_illegal = (mem_ren && mem_wen) || addr_illegal(mem_addr, ADDR_WIDTH);
  assign req_accept  = req_valid && !req_illegal;
  assign req_op      = mem_wen ? OP_WR : OP_RD;
  assign req_waddr   = mem_addr[ADDR_WIDTH+1:2];

  // The access commits on the edge that enters DONE. With no wait states that
  // edge is the accept edge itself, so the live request feeds the array;
  // otherwise the captured request does.
  assign commit   = (NO_WAIT && req_accept) ||
                    ((state_q == ST_BUSY) && cpu_en && (cnt_q == CNT_ONE));
  assign acc_op   = in_idle ? req_op    : op_q;
  assign acc_addr = in_idle ? req_waddr : addr_q;
  assign acc_data = in_idle ? mem_dout  : data_q;
  assign arr_we   = commit && (acc_op == OP_WR);
  assign arr_re   = commit && (acc_op == OP_RD);

  // State, counter and captured-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_RD;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Next-state, capture, error and stall decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    addr_d    = addr_q;
    data_d    = data_q;
    err_d     = 1'b0;
    mem_stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_illegal) begin
            // Rejected outright: no access, no stall, error next cycle.
            err_d = 1'b1;
          end else begin
            mem_stall = 1'b1;
            op_d      = req_op;
            addr_d    = req_waddr;
            data_d    = mem_dout;
            if (NO_WAIT) begin
              state_d = ST_DONE;
            end else begin
              cnt_d   = WAIT_LOAD;
              state_d = ST_BUSY;
            end
          end
        end
      end
      ST_BUSY: begin
        mem_stall = 1'b1;
        // A disabled core freezes the wait count.
        if (cpu_en) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // Single cycle; the still-held request is deliberately ignored here.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  dmem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (32)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .re_i    (arr_re),
    .we_i    (arr_we),
    .addr_i  (acc_addr),
    .wdata_i (acc_data),
    .rdata_o (mem_din)
  );

  assign mem_err = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with two wait states, one with none.
// Directed table, a reset-during-access sequence and randomized traffic
// checked against a transaction-level memory model.
module tb_dmem_responder;

  localparam int AW = 10;
  localparam int W2 = 2;
  localparam int W0 = 0;

  logic        clk;
  logic        rst_n;
  logic        en_w2, en_w0;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_dout;
  logic [31:0] din_w2, din_w0;
  logic        stall_w2, stall_w0;
  logic        err_w2, err_w0;

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  // Transaction-level reference: memory contents and last read value per DUT
  // (index 1 = two wait states, index 0 = no wait states).
  logic [31:0] ref_mem  [2][1 << AW];
  logic [31:0] last_din [2];

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n), .cpu_en(en_w2), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(din_w2),
    .mem_stall(stall_w2), .mem_err(err_w2));

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W0)) u_dut_w0 (
    .clk(clk), .rst_n(rst_n), .cpu_en(en_w0), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(din_w0),
    .mem_stall(stall_w0), .mem_err(err_w0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          sel;
    logic        ren, wen;
    logic [31:0] addr, data;
    int          off, len;
    bit          alt;
    logic [31:0] alt_addr, alt_data;
    int          exp_stall;
    logic        exp_err;
    logic [31:0] exp_din;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit sel, logic ren, logic wen, logic [31:0] addr,
                              logic [31:0] data, int off, int len, bit alt,
                              logic [31:0] aa, logic [31:0] ad, int es,
                              logic ee, logic [31:0] ed);
    vec_t v;
    v.sel = sel; v.ren = ren; v.wen = wen; v.addr = addr; v.data = data;
    v.off = off; v.len = len; v.alt = alt; v.alt_addr = aa; v.alt_data = ad;
    v.exp_stall = es; v.exp_err = ee; v.exp_din = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_en(input bit sel, input logic v);
    en_w2 = sel ? v : 1'b0;
    en_w0 = sel ? 1'b0 : v;
  endtask

  // Expected outcome of one request from the memory-port rules.
  task automatic model(input bit sel, input logic ren, input logic wen,
                       input logic [31:0] addr, input logic [31:0] data, input int len,
                       output int es, output logic ee, output logic [31:0] ed);
    int w;
    int idx;
    bit legal;
    w     = sel ? W2 : W0;
    legal = !(ren && wen) && (addr % 4 == 0) && (addr < (32'd4 << AW));
    idx   = int'(addr / 4) % (1 << AW);
    if (!legal) begin
      es = 0; ee = 1'b1; ed = last_din[sel];
    end else if (wen) begin
      ref_mem[sel][idx] = data;
      es = 1 + w + len; ee = 1'b0; ed = last_din[sel];
    end else begin
      last_din[sel] = ref_mem[sel][idx];
      es = 1 + w + len; ee = 1'b0; ed = last_din[sel];
    end
  endtask

  // Drive one request (entered #1 after a rising edge), hold it while stalled,
  // then observe the error pulse and held read data over two more cycles.
  task automatic do_txn(input bit sel, input logic ren, input logic wen,
                        input logic [31:0] addr, input logic [31:0] data,
                        input int off, input int len, input bit alt,
                        input logic [31:0] aa, input logic [31:0] ad,
                        input int es, input logic ee, input logic [31:0] ed);
    int c;
    int n_stall;
    bit done;
    logic err0, err1, err2;
    logic [31:0] din0, din1;
    mem_ren = ren; mem_wen = wen; mem_addr = addr; mem_dout = data;
    c = 0; n_stall = 0; done = 0; err0 = 1'b0; din0 = '0;
    while (!done && c < 64) begin
      set_en(sel, !(c >= off && c < off + len));
      if (c == 1 && alt) begin
        mem_addr = aa; mem_dout = ad;
      end
      @(negedge clk);
      if (sel ? stall_w2 : stall_w0) begin
        n_stall++;
      end else begin
        done = 1;
        din0 = sel ? din_w2 : din_w0;
        err0 = sel ? err_w2 : err_w0;
      end
      @(posedge clk); #1;
      c++;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL timeout: stall never released after %0d cycles, expected %0d", c, es);
    end
    mem_ren = 1'b0; mem_wen = 1'b0;
    set_en(sel, 1'b0);
    @(negedge clk);
    err1 = sel ? err_w2 : err_w0;
    @(posedge clk); #1;
    @(negedge clk);
    err2 = sel ? err_w2 : err_w0;
    din1 = sel ? din_w2 : din_w0;
    @(posedge clk); #1;
    $display("txn %0d W%0d ren=%0b wen=%0b addr=%h stall=%0d err=%0b din=%h",
             n_txn, sel ? W2 : W0, ren, wen, addr, n_stall, err1, din0);
    n_txn++;
    chk("stall_cycles", n_stall, es);
    chk("err_in_final_cycle", {31'd0, err0}, 32'd0);
    chk("err_pulse", {31'd0, err1}, {31'd0, ee});
    chk("err_pulse_end", {31'd0, err2}, 32'd0);
    chk("din_at_done", din0, ed);
    chk("din_held", din1, ed);
  endtask

  task automatic txn_model(input bit sel, input logic ren, input logic wen,
                           input logic [31:0] addr, input logic [31:0] data,
                           input int off, input int len, input bit alt,
                           input logic [31:0] aa, input logic [31:0] ad);
    int es; logic ee; logic [31:0] ed;
    model(sel, ren, wen, addr, data, len, es, ee, ed);
    do_txn(sel, ren, wen, addr, data, off, len, alt, aa, ad, es, ee, ed);
  endtask

  initial begin
    int es; logic ee; logic [31:0] ed;
    last_din[0] = '0; last_din[1] = '0;
    rst_n = 1'b0; en_w2 = 1'b0; en_w0 = 1'b0;
    mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_dout = '0;

    // Directed vectors: {sel, ren, wen, addr, data, off, len, alt, alt_addr,
    // alt_data, expected stall cycles, expected error pulse, expected din}.
    vecs.push_back(mk(1, 0, 1, 32'h10, 32'hDEADBEEF, 1, 0, 0, 0, 0, 3, 0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h10, 32'h0,        1, 0, 0, 0, 0, 3, 0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0, 1, 32'h0,  32'h1,        1, 0, 0, 0, 0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h4,  32'h2,        1, 0, 0, 0, 0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,  32'h0,        1, 0, 0, 0, 0, 1, 0, 32'h1));
    vecs.push_back(mk(0, 1, 0, 32'h4,  32'h0,        1, 0, 0, 0, 0, 1, 0, 32'h2));
    vecs.push_back(mk(1, 1, 0, 32'h6,  32'h0,        1, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF));
    vecs.push_back(mk(1, 1, 1, 32'h8,  32'h0,        1, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF));
    vecs.push_back(mk(1, 1, 0, 32'h1000, 32'h0,      1, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 1, 0, 32'h2,  32'h0,        1, 0, 0, 0, 0, 0, 1, 32'h2));
    vecs.push_back(mk(1, 0, 1, 32'h14, 32'hCAFEF00D, 1, 3, 0, 0, 0, 6, 0, 32'hDEADBEEF));
    vecs.push_back(mk(1, 1, 0, 32'h14, 32'h0,        2, 3, 0, 0, 0, 6, 0, 32'hCAFEF00D));
    vecs.push_back(mk(1, 0, 1, 32'h1C, 32'h33333333, 1, 0, 0, 0, 0, 3, 0, 32'hCAFEF00D));
    vecs.push_back(mk(1, 0, 1, 32'h18, 32'h11111111, 1, 0, 1, 32'h1C, 32'h22222222, 3, 0, 32'hCAFEF00D));
    vecs.push_back(mk(1, 1, 0, 32'h18, 32'h0,        1, 0, 0, 0, 0, 3, 0, 32'h11111111));
    vecs.push_back(mk(1, 1, 0, 32'h1C, 32'h0,        1, 0, 0, 0, 0, 3, 0, 32'h33333333));
    vecs.push_back(mk(1, 0, 1, 32'h80000000, 32'h5,  1, 0, 0, 0, 0, 0, 1, 32'h33333333));
    vecs.push_back(mk(1, 0, 1, 32'h20, 32'hA5A5A5A5, 1, 0, 0, 0, 0, 3, 0, 32'h33333333));
    vecs.push_back(mk(1, 1, 0, 32'h10, 32'h0,        1, 0, 0, 0, 0, 3, 0, 32'hDEADBEEF));

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall_w2", {31'd0, stall_w2}, 32'd0);
    chk("rst_err_w2",   {31'd0, err_w2},   32'd0);
    chk("rst_din_w2",   din_w2,            32'd0);
    chk("rst_stall_w0", {31'd0, stall_w0}, 32'd0);
    chk("rst_err_w0",   {31'd0, err_w0},   32'd0);
    chk("rst_din_w0",   din_w0,            32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < vecs.size(); i++) begin
      model(vecs[i].sel, vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].data,
            vecs[i].len, es, ee, ed);
      do_txn(vecs[i].sel, vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].data,
             vecs[i].off, vecs[i].len, vecs[i].alt, vecs[i].alt_addr, vecs[i].alt_data,
             vecs[i].exp_stall, vecs[i].exp_err, vecs[i].exp_din);
    end

    // Reset during the busy phase of a write to 0x20.
    mem_ren = 1'b0; mem_wen = 1'b1; mem_addr = 32'h20; mem_dout = 32'h12345678;
    set_en(1, 1'b1);
    @(negedge clk);
    chk("midrst_accept_stall", {31'd0, stall_w2}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_busy_stall", {31'd0, stall_w2}, 32'd1);
    #1;
    rst_n = 1'b0; mem_wen = 1'b0; set_en(1, 1'b0);
    #1;
    chk("midrst_stall", {31'd0, stall_w2}, 32'd0);
    chk("midrst_din",   din_w2,            32'd0);
    chk("midrst_err",   {31'd0, err_w2},   32'd0);
    last_din[0] = '0; last_din[1] = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_txn(1, 1, 0, 32'h20, 32'h0, 1, 0, 0, 0, 0, 3, 0, 32'hA5A5A5A5);
    model(1, 1, 0, 32'h20, 32'h0, 0, es, ee, ed);
    chk("midrst_model_view", ed, 32'hA5A5A5A5);

    // Preload a small address window in both instances, then random traffic.
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 8; w++) begin
        txn_model(s[0], 0, 1, 32'(w * 4), $urandom, 1, 0, 0, 0, 0);
      end
    end
    for (int t = 0; t < 150; t++) begin
      bit          sel;
      int          kind, pick, len, off;
      logic        ren, wen;
      logic [31:0] addr, aa;
      bit          alt;
      sel  = $urandom_range(0, 3) != 0;
      kind = $urandom_range(0, 9);
      ren  = (kind < 5) || (kind == 9);
      wen  = (kind >= 5);
      pick = $urandom_range(0, 11);
      if (pick < 10)       addr = 32'($urandom_range(0, 7) * 4);
      else if (pick == 10) addr = 32'($urandom_range(0, 7) * 4 + 2);
      else                 addr = 32'h1000 | 32'($urandom_range(0, 7) * 4);
      len  = sel ? $urandom_range(0, 3) : 0;
      off  = $urandom_range(1, 2);
      alt  = $urandom_range(0, 3) == 0;
      aa   = 32'($urandom_range(0, 7) * 4);
      txn_model(sel, ren, wen, addr, $urandom, off, len, alt, aa, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU datapath's data port.
- Accepts the datapath's read/write requests (mem_ren, mem_wen, mem_addr, mem_dout) and returns read data on mem_din.
- Models a word-addressed on-chip SRAM with a configurable wait-state count.
- Drives a stall back to the pipeline while an access is in flight; flags illegal requests.

Parameters:
- ADDR_WIDTH, 10, word-address bits; array depth is 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2, extra stall cycles per legal access; legal range 0..15.

Ports:
- clk  in  1  main clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_en  in  1  enable; when 0, no new request is accepted and the wait counter freezes.
- mem_ren  in  1  read request from the datapath.
- mem_wen  in  1  write request from the datapath.
- mem_addr  in  32  byte address.
- mem_dout  in  32  write data from the datapath.
- mem_din  out  32  read data to the datapath.
- mem_stall  out  1  pipeline hold; the requester keeps its request stable while this is high.
- mem_err  out  1  one-cycle pulse for an illegal request.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, mem_din=0, mem_err=0, pending address/data/op registers cleared. mem_stall=0 because it is derived from state. Array contents are not reset.
- A request is valid when (mem_ren|mem_wen) is high in IDLE with cpu_en=1.
- A request is illegal when any of these holds:
  - mem_ren and mem_wen are both high;
  - mem_addr[1:0] != 0;
  - mem_addr[31:ADDR_WIDTH+2] != 0.
- Illegal request: no array access, no stall, and mem_err=1 in the next cycle only. State stays IDLE and mem_din holds its value.
- States: IDLE, BUSY, DONE (encoding in package).
- IDLE, legal request in cycle N:
  - capture op, word address mem_addr[ADDR_WIDTH+1:2] and mem_dout;
  - if WAIT_CYCLES=0, go to DONE; otherwise load cnt=WAIT_CYCLES and go to BUSY.
- BUSY: when cpu_en=1, decrement cnt; when cnt==1 and cpu_en=1, go to DONE. When cpu_en=0, cnt holds.
- Access commit on entry to DONE (same edge):
  - write: array[waddr] <= captured data;
  - read: mem_din <= array[raddr].
- DONE: lasts exactly 1 cycle, then IDLE. Inputs are ignored in DONE, so the held request is not re-accepted.
- mem_stall = (IDLE & legal valid request) | BUSY. It is combinational from state and inputs, so it is high in cycles N..N+WAIT_CYCLES and low in DONE.
- Latency: read data is valid on mem_din in cycle N+WAIT_CYCLES+1, which is the DONE cycle. mem_din holds its value until the next read commits.
- The earliest back-to-back request is accepted in the cycle after DONE; throughput is 1 access per WAIT_CYCLES+2 cycles.
- Inputs that change during BUSY are ignored; only the captured request is executed.
- Reset mid-access: the pending write is discarded (array unchanged), the pending read is dropped, and mem_din returns to 0.
- cnt width is 4 bits; WAIT_CYCLES > 15 is a parameter error (elaboration-time check).

Decomposition:
- Shared include (alongside the existing define headers): state encodings ST_IDLE/ST_BUSY/ST_DONE (2 bits) and the op encoding OP_RD/OP_WR.
- One sub-module, dmem_array: single-port, 2^ADDR_WIDTH x 32, synchronous write, synchronous registered read, with addr, we, wdata and rdata ports.
- The responder FSM, counter and legality check live in dmem_responder.

Test Plan:
- Reset, WAIT_CYCLES=2, write 0xDEADBEEF to 0x10 in cycle N:
  - mem_stall high in N..N+2, low in N+3;
  - a subsequent read of 0x10 returns 0xDEADBEEF on mem_din 3 cycles after its accept.
- WAIT_CYCLES=0, read then read at 0x0 and 0x4 after preloading 1 and 2: mem_stall high only in the accept cycle; mem_din=1 then 2 on successive DONE cycles.
- Illegal requests: read at 0x6, ren&wen at 0x8, read at 0x1000 with ADDR_WIDTH=10 → each gives mem_err=1 for one cycle, no stall, and mem_din unchanged.
- cpu_en dropped for 3 cycles during BUSY with WAIT_CYCLES=2: stall is extended by exactly 3 cycles and data is correct.
- rst_n asserted during BUSY of a write of 0x12345678 to 0x20: state=IDLE, stall=0, mem_din=0 immediately; a later read of 0x20 returns the prior value.
- Inputs changed to a different address during BUSY: the original captured address is accessed and the new one is untouched.
